// File: rtl/digit_timer_pkg.sv
// digit_timer_pkg: shared BCD constants and digit indices for the mm:ss countdown timer
package digit_timer_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;
  typedef enum logic [1:0] {SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS} digit_idx_e;
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit that parallel-loads or decrements, wrapping to WRAP with a borrow
module bcd_down_digit
  import digit_timer_pkg::*;
#(
  parameter int WRAP = 9
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] d_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);
  assign borrow_out = dec && q == BCD_ZERO;
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) q <= BCD_ZERO;
    else if (load) q <= d_in;
    else if (dec) q <= q == BCD_ZERO ? BCD_W'(WRAP) : q - BCD_W'(1);
endmodule

// File: rtl/digit_timer.sv
// digit_timer: keypad-loaded mm:ss BCD countdown with 1 Hz decrement and zero flag
// Optional one-cycle done pulse on count-out is enabled with DIGIT_TIMER_DONE_EN.
module digit_timer
  import digit_timer_pkg::*;
#(
  parameter int SEC_TENS_WRAP = 5,
  parameter int MIN_TENS_MAX = 9
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [BCD_W-1:0] D,
  input  logic             loadn,
  input  logic             pgt_1Hz,
  input  logic             countn,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] min_tens,
  output logic             zero,
  output logic             done
);
  logic loadn_q, tick_q, load_ev, tick_ev, shift, step, unused_borrow;
  logic [BCD_W-1:0] q [4];
  logic [BCD_W-1:0] d_in [4];
  logic [3:0] dec, borrow;
  // Reset values chosen so held-active inputs at release produce no edge
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) begin
      loadn_q <= 1'b0;
      tick_q <= 1'b1;
    end else begin
      loadn_q <= loadn;
      tick_q <= pgt_1Hz;
    end
  assign load_ev = !loadn && loadn_q;
  assign tick_ev = pgt_1Hz && !tick_q;
  assign shift = countn && load_ev && D <= BCD_MAX;
  assign step = !countn && tick_ev && !zero;
  assign d_in[SEC_ONES] = D;
  assign d_in[SEC_TENS] = q[SEC_ONES];
  assign d_in[MIN_ONES] = q[SEC_TENS];
  assign d_in[MIN_TENS] = q[MIN_ONES] > BCD_W'(MIN_TENS_MAX) ? BCD_W'(MIN_TENS_MAX) : q[MIN_ONES];
  assign dec = {borrow[2:0], step};
  assign unused_borrow = borrow[3];
  genvar i;
  for (i = 0; i < 4; i++) begin : g_digit
    bcd_down_digit #(
      .WRAP(i == 1 ? SEC_TENS_WRAP : i == 3 ? MIN_TENS_MAX : int'(BCD_MAX))
    ) u_digit (
      .clk       (clk),
      .clearn    (clearn),
      .dec       (dec[i]),
      .load      (shift),
      .d_in      (d_in[i]),
      .q         (q[i]),
      .borrow_out(borrow[i])
    );
  end
  assign sec_ones = q[SEC_ONES];
  assign sec_tens = q[SEC_TENS];
  assign min_ones = q[MIN_ONES];
  assign min_tens = q[MIN_TENS];
  assign zero = {min_tens, min_ones, sec_tens, sec_ones} == '0;
`ifdef DIGIT_TIMER_DONE_EN
  // Only a decrement from 00:01 can land on zero
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) done <= 1'b0;
    else done <= step && {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;
`else
  assign done = 1'b0;
`endif
endmodule

// File: tb/tb_digit_timer.sv
// tb_digit_timer: directed self-checking bench for digit_timer
module tb_digit_timer;
  logic clk = 1'b0, clearn, loadn, pgt_1Hz, countn, zero, done;
  logic [3:0] D, sec_ones, sec_tens, min_ones, min_tens;
  logic [15:0] val;
  int n_cmp = 0, n_bad = 0, done_cnt = 0, base;
  always #5 clk = ~clk;
  assign val = {min_tens, min_ones, sec_tens, sec_ones};
  digit_timer dut (
    .clk     (clk),
    .clearn  (clearn),
    .D       (D),
    .loadn   (loadn),
    .pgt_1Hz (pgt_1Hz),
    .countn  (countn),
    .sec_ones(sec_ones),
    .sec_tens(sec_tens),
    .min_ones(min_ones),
    .min_tens(min_tens),
    .zero    (zero),
    .done    (done)
  );
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [3:0] d, input int n);
    D = d;
    loadn = 1'b0;
    repeat (n) @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
  endtask
  task automatic tick(input int n);
    pgt_1Hz = 1'b1;
    repeat (n) @(negedge clk);
    pgt_1Hz = 1'b0;
    @(negedge clk);
  endtask
  task automatic load4(input logic [15:0] v);
    countn = 1'b1;
    strobe(v[15:12], 1);
    strobe(v[11:8], 1);
    strobe(v[7:4], 1);
    strobe(v[3:0], 1);
  endtask
  initial begin
    clearn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; countn = 1'b1; D = '0;
    repeat (2) @(negedge clk);
    check("reset_val", val, 16'h0000);
    check("reset_zero", zero, 1);
    check("reset_done", done, 0);
    clearn = 1'b1;
    @(negedge clk);
    strobe(4'd5, 5);
    check("entry_5", val, 16'h0005);
    strobe(4'd1, 5);
    check("entry_51", val, 16'h0051);
    check("entry_nonzero", zero, 0);
    strobe(4'd12, 3);
    check("invalid_digit", val, 16'h0051);
    countn = 1'b0;
    strobe(4'd7, 3);
    check("count_lockout", val, 16'h0051);
    load4(16'h1000);
    check("load_1000", val, 16'h1000);
    countn = 1'b0;
    tick(1);
    check("borrow_0959", val, 16'h0959);
    load4(16'h0190);
    countn = 1'b0;
    tick(1); tick(1); tick(1);
    check("sec_tens_9", val, 16'h0187);
    load4(16'h0002);
    base = done_cnt;
    check("entry_no_done", done_cnt - base, 0);
    countn = 1'b0;
    tick(1);
    check("term_0001", val, 16'h0001);
    tick(1);
    check("term_0000", val, 16'h0000);
    check("term_zero", zero, 1);
`ifdef DIGIT_TIMER_DONE_EN
    check("done_once", done_cnt - base, 1);
`else
    check("done_off", done_cnt - base, 0);
`endif
    base = done_cnt;
    tick(1);
    check("hold_0000", val, 16'h0000);
    check("hold_no_done", done_cnt - base, 0);
    load4(16'h0030);
    countn = 1'b0;
    tick(20);
    check("wide_tick", val, 16'h0029);
    load4(16'h0328);
    countn = 1'b0;
    tick(1);
    check("pre_reset", val, 16'h0327);
    #2 clearn = 1'b0;
    #1;
    check("async_clear", val, 16'h0000);
    check("async_zero", zero, 1);
    countn = 1'b1; loadn = 1'b0; pgt_1Hz = 1'b1; D = 4'd4;
    @(negedge clk);
    clearn = 1'b1;
    repeat (3) @(negedge clk);
    check("release_no_shift", val, 16'h0000);
    loadn = 1'b1; pgt_1Hz = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
